// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_FETCH = 2'd1,
    FC_STALL = 2'd2,
    FC_DRAIN = 2'd3
  } fc_state_e;

  localparam int unsigned ARM_INC   = 4;
  localparam int unsigned THUMB_INC = 2;
  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_IR = 32'h0;

  // Little-endian halfword pick for Thumb, whole word for ARM.
  function automatic logic [INSTR_W-1:0] select_instr(input logic [31:0] word,
                                                      input logic        thumb,
                                                      input logic        upper);
    if (!thumb) return word;
    return upper ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO with wrap-around pointers; flush wins over push and pop.
module fetch_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; consumers only look at it when not empty.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: address generation, memory handshake,
// prefetch buffering and branch redirect for ARM/Thumb streams.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       BUF_DEPTH    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [31:0]       IR,
  output logic              FETCH_EN,
  input  logic              DEC_READY,
  output logic [ADDR_W-1:0] PC_OUT,
  input  logic              BRANCH_EN,
  input  logic [ADDR_W-1:0] BRANCH_ADDR,
  input  logic              T_BIT
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;

  fc_state_e         state;
  fc_state_e         state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] drain_addr;
  logic              t_mode;

  logic [ADDR_W-1:0]  fetch_addr_c;
  logic [ADDR_W-1:0]  branch_target_c;
  logic [ADDR_W-1:0]  pc_inc_c;
  logic [INSTR_W-1:0] instr_c;
  logic [ENTRY_W-1:0] entry_c;
  logic [ENTRY_W-1:0] head_c;
  logic [CNT_W-1:0]   count_c;
  logic               req_c;
  logic               push_c;
  logic               pop_c;
  logic               fills_c;
  logic               full_c;
  logic               empty_c;

  assign fetch_addr_c    = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign req_c           = (state == FC_FETCH) || (state == FC_DRAIN);
  assign instr_c         = select_instr(MEM_RDATA, t_mode, fetch_pc[1]);
  assign entry_c         = {fetch_pc, instr_c};
  assign push_c          = (state == FC_FETCH) && MEM_ACK && !BRANCH_EN;
  assign pop_c           = FETCH_EN && DEC_READY;
  assign fills_c         = push_c && !pop_c && (count_c == CNT_W'(BUF_DEPTH - 1));
  assign pc_inc_c        = t_mode ? ADDR_W'(THUMB_INC) : ADDR_W'(ARM_INC);
  assign branch_target_c = T_BIT ? {BRANCH_ADDR[ADDR_W-1:1], 1'b0}
                                 : {BRANCH_ADDR[ADDR_W-1:2], 2'b00};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FC_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a branch overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      FC_IDLE:  state_nxt = FC_FETCH;
      FC_FETCH: if (MEM_ACK) state_nxt = fills_c ? FC_STALL : FC_FETCH;
      FC_STALL: if (!full_c || pop_c) state_nxt = FC_FETCH;
      FC_DRAIN: if (MEM_ACK) state_nxt = FC_FETCH;
      default:  state_nxt = FC_IDLE;
    endcase
    if (BRANCH_EN) state_nxt = (req_c && !MEM_ACK) ? FC_DRAIN : FC_FETCH;
  end

  always_comb begin
    MEM_REQ  = 1'b0;
    MEM_ADDR = fetch_addr_c;
    case (state)
      FC_FETCH: MEM_REQ = 1'b1;
      FC_DRAIN: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = drain_addr;
      end
      default: ;
    endcase
  end

  // drain_addr shadows the live address so an abandoned request keeps it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc   <= RESET_VECTOR;
      t_mode     <= 1'b0;
      drain_addr <= {RESET_VECTOR[ADDR_W-1:2], 2'b00};
    end else begin
      if (state != FC_DRAIN) drain_addr <= fetch_addr_c;
      if (BRANCH_EN) begin
        fetch_pc <= branch_target_c;
        t_mode   <= T_BIT;
      end else if (push_c) begin
        fetch_pc <= fetch_pc + pc_inc_c;
      end
    end
  end

  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_c),
    .pop       (pop_c),
    .flush     (BRANCH_EN),
    .push_data (entry_c),
    .head_data (head_c),
    .full      (full_c),
    .empty     (empty_c),
    .count     (count_c)
  );

  assign FETCH_EN = !empty_c;
  assign IR       = empty_c ? NOP_IR : head_c[INSTR_W-1:0];
  assign PC_OUT   = empty_c ? '0 : head_c[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against an
// instruction-stream reference model and a simple wait-state memory.
module tb_fetch_controller;

  logic        CLK;
  logic        RST;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [31:0] IR;
  logic        FETCH_EN;
  logic        DEC_READY;
  logic [31:0] PC_OUT;
  logic        BRANCH_EN;
  logic [31:0] BRANCH_ADDR;
  logic        T_BIT;

  int checks = 0;
  int errors = 0;

  int unsigned fixed_wait = 0;
  int unsigned max_wait   = 3;
  bit          rand_waits = 1'b0;
  int unsigned wait_cnt;
  int unsigned cur_wait;

  // Reference model: the stream decode should see, one instruction at a time.
  logic [31:0] exp_pc;
  bit          exp_thumb;
  bit          branch_prev;
  bit          pend_prev;
  logic [31:0] pend_addr;
  int          consumed;

  fetch_controller dut (
    .CLK         (CLK),
    .RST         (RST),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_RDATA   (MEM_RDATA),
    .MEM_ACK     (MEM_ACK),
    .IR          (IR),
    .FETCH_EN    (FETCH_EN),
    .DEC_READY   (DEC_READY),
    .PC_OUT      (PC_OUT),
    .BRANCH_EN   (BRANCH_EN),
    .BRANCH_ADDR (BRANCH_ADDR),
    .T_BIT       (T_BIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_0001;
      32'h0000_0004: return 32'hE3A0_1002;
      32'h0000_0200: return 32'h4770_2001;
      default:       return {a[17:2] ^ 16'hC3A5, a[17:2] + 16'h1111};
    endcase
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc, input bit thumb);
    logic [31:0] w;
    w = mem_word({pc[31:2], 2'b00});
    if (!thumb) return w;
    return pc[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
  endfunction

  // Memory: acknowledges after cur_wait extra cycles of a held request.
  assign MEM_ACK   = MEM_REQ && (wait_cnt >= cur_wait);
  assign MEM_RDATA = mem_word(MEM_ADDR);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= 0;
      cur_wait <= fixed_wait;
    end else if (MEM_REQ && !MEM_ACK) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      cur_wait <= rand_waits ? $urandom_range(max_wait, 0) : fixed_wait;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluates the current cycle against the model, just before the edge.
  task automatic model_cycle();
    if (RST) begin
      exp_pc      = 32'h0;
      exp_thumb   = 1'b0;
      branch_prev = 1'b0;
      pend_prev   = 1'b0;
      pend_addr   = 32'h0;
      return;
    end
    if (!FETCH_EN) begin
      chk("idle_ir", IR, 0);
      chk("idle_pc", PC_OUT, 0);
    end
    if (branch_prev) chk("flush_fetch_en", FETCH_EN, 0);
    if (pend_prev) begin
      chk("req_held", MEM_REQ, 1);
      chk("addr_held", MEM_ADDR, pend_addr);
    end
    if (MEM_REQ) chk("addr_aligned", MEM_ADDR[1:0], 0);
    if (FETCH_EN && DEC_READY) begin
      chk("stream_pc", PC_OUT, exp_pc);
      chk("stream_ir", IR, exp_instr(exp_pc, exp_thumb));
      exp_pc = exp_pc + (exp_thumb ? 32'd2 : 32'd4);
      consumed++;
    end
    if (BRANCH_EN) begin
      exp_thumb = T_BIT;
      exp_pc    = T_BIT ? {BRANCH_ADDR[31:1], 1'b0} : {BRANCH_ADDR[31:2], 2'b00};
    end
    branch_prev = BRANCH_EN;
    pend_prev   = MEM_REQ && !MEM_ACK;
    pend_addr   = MEM_ADDR;
  endtask

  task automatic tick();
    model_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in the first cycle after RST falls.
  task automatic do_reset();
    RST       = 1'b1;
    BRANCH_EN = 1'b0;
    repeat (2) tick();
    chk("rst_req", MEM_REQ, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_fetch_en", FETCH_EN, 0);
    chk("rst_ir", IR, 0);
    chk("rst_pc", PC_OUT, 0);
    RST = 1'b0;
  endtask

  initial begin
    bit found;
    RST = 1'b1; DEC_READY = 1'b1; BRANCH_EN = 1'b0; BRANCH_ADDR = 32'h0; T_BIT = 1'b0;
    consumed = 0;

    // Zero-wait straight-line fetch.
    fixed_wait = 0; DEC_READY = 1'b1;
    do_reset();
    chk("t1_idle_req", MEM_REQ, 0);
    tick();
    chk("t1_req", MEM_REQ, 1);
    chk("t1_addr", MEM_ADDR, 32'h0);
    chk("t1_fe0", FETCH_EN, 0);
    tick();
    chk("t1_fe1", FETCH_EN, 1);
    chk("t1_ir0", IR, 32'hE3A0_0001);
    chk("t1_pc0", PC_OUT, 32'h0);
    tick();
    chk("t1_ir1", IR, 32'hE3A0_1002);
    chk("t1_pc1", PC_OUT, 32'h4);

    // Decode stalled: buffer fills and requests stop.
    DEC_READY = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("t2_stall_req", MEM_REQ, 0);
    chk("t2_ir", IR, 32'hE3A0_0001);
    chk("t2_pc", PC_OUT, 32'h0);
    repeat (2) tick();
    chk("t2_still_req", MEM_REQ, 0);
    chk("t2_still_ir", IR, 32'hE3A0_0001);
    DEC_READY = 1'b1;
    tick();
    chk("t2_resume_req", MEM_REQ, 1);
    chk("t2_resume_addr", MEM_ADDR, 32'h8);
    chk("t2_resume_pc", PC_OUT, 32'h4);
    tick();

    // Three wait states per access.
    fixed_wait = 3; DEC_READY = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t3_req", MEM_REQ, 1);
      chk("t3_addr", MEM_ADDR, 32'h0);
      chk("t3_ack", MEM_ACK, (c == 4));
      chk("t3_fe_wait", FETCH_EN, 0);
    end
    tick();
    chk("t3_fe", FETCH_EN, 1);
    chk("t3_pc0", PC_OUT, 32'h0);
    chk("t3_addr4", MEM_ADDR, 32'h4);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_gap", FETCH_EN, 0);
    end
    tick();
    chk("t3_fe2", FETCH_EN, 1);
    chk("t3_pc4", PC_OUT, 32'h4);

    // Branch with a request pending: drain the old access.
    fixed_wait = 3;
    do_reset();
    repeat (2) tick();
    BRANCH_EN = 1'b1; BRANCH_ADDR = 32'h100; T_BIT = 1'b0;
    tick();
    BRANCH_EN = 1'b0;
    chk("t4_drain_req", MEM_REQ, 1);
    chk("t4_drain_addr", MEM_ADDR, 32'h0);
    tick();
    chk("t4_drain_ack", MEM_ACK, 1);
    tick();
    chk("t4_target_addr", MEM_ADDR, 32'h100);
    chk("t4_target_fe", FETCH_EN, 0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (FETCH_EN) found = 1'b1;
      else tick();
    end
    chk("t4_found", found, 1);
    chk("t4_pc", PC_OUT, 32'h100);
    chk("t4_ir", IR, mem_word(32'h100));
    tick();

    // Branch into Thumb at an upper halfword.
    fixed_wait = 0;
    do_reset();
    tick();
    BRANCH_EN = 1'b1; BRANCH_ADDR = 32'h202; T_BIT = 1'b1;
    tick();
    BRANCH_EN = 1'b0; T_BIT = 1'b0;
    chk("t5_fe0", FETCH_EN, 0);
    chk("t5_addr", MEM_ADDR, 32'h200);
    tick();
    chk("t5_ir", IR, 32'h0000_4770);
    chk("t5_pc", PC_OUT, 32'h202);
    chk("t5_next_addr", MEM_ADDR, 32'h204);
    tick();
    chk("t5_pc2", PC_OUT, 32'h204);

    // Reset mid-request with buffered data.
    fixed_wait = 3; DEC_READY = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t6_pre_req", MEM_REQ, 1);
    chk("t6_pre_fe", FETCH_EN, 1);
    RST = 1'b1;
    #1;
    chk("t6_req", MEM_REQ, 0);
    chk("t6_fe", FETCH_EN, 0);
    chk("t6_ir", IR, 0);
    chk("t6_pc", PC_OUT, 0);
    tick();
    fixed_wait = 0; DEC_READY = 1'b1;
    do_reset();
    tick();
    chk("t6_restart_req", MEM_REQ, 1);
    chk("t6_restart_addr", MEM_ADDR, 32'h0);

    // Reset while stalled with a full buffer.
    DEC_READY = 1'b0;
    do_reset();
    repeat (3) tick();
    chk("t7_pre_fe", FETCH_EN, 1);
    RST = 1'b1;
    #1;
    chk("t7_fe", FETCH_EN, 0);
    chk("t7_ir", IR, 0);
    tick();

    // Randomized waits, decode back-pressure and branches (some near wrap).
    rand_waits = 1'b1; DEC_READY = 1'b1;
    do_reset();
    consumed = 0;
    for (int i = 0; i < 4000; i++) begin
      DEC_READY = ($urandom_range(3, 0) != 0);
      BRANCH_EN = ($urandom_range(15, 0) == 0);
      if (BRANCH_EN) begin
        T_BIT       = $urandom_range(1, 0);
        BRANCH_ADDR = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : ($urandom & 32'h0000_3FFF);
      end
      tick();
    end
    BRANCH_EN = 1'b0;
    rand_waits = 1'b0;
    chk("rand_progress", (consumed > 300), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
